// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state type and lane-select helpers for the load/store unit
package lsu_pkg;
    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsuState_t;
    // bit offset of the addressed lane inside the word (word and size 11 use lane 0)
    function automatic logic [4:0] laneShift(input logic [1:0] size, input logic [1:0] addrLo);
        return size == LSU_BYTE ? {addrLo, 3'b000} : size == LSU_HALF ? {addrLo[1], 4'b0000} : 5'd0;
    endfunction
    function automatic logic [31:0] laneMask(input logic [1:0] size, input logic [1:0] addrLo);
        return (size == LSU_BYTE ? 32'h0000_00FF : size == LSU_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF)
               << laneShift(size, addrLo);
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit
//  size/addrLo/isUnsigned : latched request attributes
//  rword                  : word read from memory
//  wdata                  : right-justified store data
//  loadData               : extracted and sign/zero-extended load result
//  mergeData              : rword with the addressed lane(s) replaced by wdata (wdata for word stores)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addrLo,
    input  logic        isUnsigned,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] loadData,
    output logic [31:0] mergeData
);
    logic [4:0]  shift;
    logic [31:0] mask;
    logic [31:0] lane;
    assign shift = laneShift(size, addrLo);
    assign mask  = laneMask(size, addrLo);
    assign lane  = rword >> shift;
    assign loadData = size == LSU_BYTE ? {{24{~isUnsigned & lane[7]}}, lane[7:0]} :
                      size == LSU_HALF ? {{16{~isUnsigned & lane[15]}}, lane[15:0]} : rword;
    assign mergeData = (rword & ~mask) | ((wdata << shift) & mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage front end for a word-only, negedge-sampled data memory
//  Clk, reset (sync, active-low)
//  req_valid/req_ready/req_write/req_size/req_unsigned/req_addr/req_wdata : pipeline request
//  resp_valid/resp_rdata : one-cycle completion pulse and load result
//  busy                  : high whenever not idle
//  MemRead/MemWrite/Address/WriteData/ReadData : data memory interface
//  misalign              : only with MISALIGN_TRAP_EN defined; flags a trapped misaligned access
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        busy,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    input  logic [31:0] ReadData
);
    lsuState_t         state, nextState;
    logic [ADDR_W+1:0] addrQ;
    logic [1:0]        sizeQ;
    logic              unsQ, writeQ, misQ;
    logic [31:0]       wdataQ, rword, loadData, mergeData;
    logic              accept, isWord, misNow;
    logic              unusedAddr;
    assign unusedAddr = ^req_addr[31:ADDR_W+2];
    assign accept = req_valid && state == IDLE;
    assign isWord = req_size >= LSU_WORD;
`ifdef MISALIGN_TRAP_EN
    assign misNow = (req_size == LSU_HALF && req_addr[0]) || (isWord && |req_addr[1:0]);
    assign misalign = state == RESP && misQ;
`else
    assign misNow = 1'b0;
`endif
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state  <= IDLE;
            addrQ  <= '0;
            sizeQ  <= '0;
            unsQ   <= 1'b0;
            writeQ <= 1'b0;
            misQ   <= 1'b0;
            wdataQ <= '0;
            rword  <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                addrQ  <= req_addr[ADDR_W+1:0];
                sizeQ  <= req_size;
                unsQ   <= req_unsigned;
                writeQ <= req_write;
                misQ   <= misNow;
                wdataQ <= req_wdata;
            end
            if (state == RD)
                rword <= ReadData;
        end
    end
    // word stores skip the read; trapped accesses go straight to the response
    always_comb begin
        nextState = IDLE;
        nextState = state == IDLE ? (req_valid ? (misNow ? RESP : (req_write && isWord) ? WR : RD) : IDLE) :
                    state == RD   ? (writeQ ? WR : RESP) :
                    state == WR   ? RESP : IDLE;
    end
    lsu_align align (
        .size      (sizeQ),
        .addrLo    (addrQ[1:0]),
        .isUnsigned(unsQ),
        .rword     (rword),
        .wdata     (wdataQ),
        .loadData  (loadData),
        .mergeData (mergeData)
    );
    assign req_ready  = state == IDLE;
    assign busy       = state != IDLE;
    assign resp_valid = state == RESP;
    assign MemRead    = state == RD;
    assign MemWrite   = state == WR;
    assign Address    = {{(32-ADDR_W){1'b0}}, addrQ[ADDR_W+1:2]};
    assign WriteData  = state == WR ? mergeData : 32'd0;
    assign resp_rdata = (state == RESP && !writeQ && !misQ) ? loadData : 32'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: load_store_unit paired with a negedge data memory, checked against a transaction-level model
module tb_load_store_unit;
    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, busy, MemRead, MemWrite;
    logic [31:0] resp_rdata, Address, WriteData;
    logic [31:0] ReadData = '0;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    load_store_unit #(.ADDR_W(5)) dut (
        .Clk(Clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
`ifdef MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .ReadData(ReadData)
    );

    always #5 Clk = ~Clk;

    // physical data memory: samples on negedge, registered read port
    logic [31:0] mem [32];
    always @(negedge Clk) begin
        if (MemWrite) mem[Address[4:0]] <= WriteData;
        if (MemRead) ReadData <= mem[Address[4:0]];
    end

    // reference contents as seen by the transaction-level model
    logic [31:0] refMem [32];

    typedef struct {
        bit          busy, rd, wr, rv, mis;
        logic [31:0] addr, wd, rdata;
    } cycT;
    cycT expQ[$];

    int passCnt = 0, total = 0, cycCnt = 0, respCyc = 0;
    bit chkOn = 0;
    logic [31:0] lastRdata = '0, lastWd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycCnt);
    endtask

    always @(posedge Clk) cycCnt++;

    // single compare process: one expected record per cycle, idle when nothing is outstanding
    always @(negedge Clk) begin
        if (chkOn) begin
            cycT e;
            e = '{default: 0};
            if (expQ.size() > 0) e = expQ.pop_front();
            chk("busy", {31'd0, busy}, {31'd0, e.busy});
            chk("req_ready", {31'd0, req_ready}, {31'd0, !e.busy});
            chk("MemRead", {31'd0, MemRead}, {31'd0, e.rd});
            chk("MemWrite", {31'd0, MemWrite}, {31'd0, e.wr});
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, e.rv});
`ifdef MISALIGN_TRAP_EN
            chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
`endif
            if (e.rd || e.wr) chk("Address", Address, e.addr);
            if (e.wr) begin
                chk("WriteData", WriteData, e.wd);
                lastWd = WriteData;
            end
            if (e.rv) begin
                chk("resp_rdata", resp_rdata, e.rdata);
                lastRdata = resp_rdata;
                respCyc = cycCnt;
            end
        end
    end

    function automatic logic [31:0] refLoad(logic [31:0] w, logic [1:0] sz, bit uns, logic [31:0] a);
        logic [31:0] v;
        logic [1:0] lo;
        lo = a[1:0];
        if (sz == 2'b00) begin
            v = (w >> (8 * lo)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (w >> (16 * lo[1])) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else v = w;
        return v;
    endfunction

    function automatic logic [31:0] refStore(logic [31:0] w, logic [31:0] wd, logic [1:0] sz, logic [31:0] a);
        logic [1:0] lo;
        int sh;
        lo = a[1:0];
        if (sz == 2'b00) begin
            sh = 8 * lo;
            return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end
        if (sz == 2'b01) begin
            sh = 16 * lo[1];
            return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    // present one request in an idle cycle; while busy keep req_valid high with junk that must be ignored
    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                         input logic [31:0] wd);
        cycT e;
        int n;
        logic [4:0] idx;
        logic [31:0] nw;
        bit mis;
        idx = a[6:2];
        mis = 0;
`ifdef MISALIGN_TRAP_EN
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`endif
        e = '{default: 0};
        expQ.push_back(e);
        n = 0;
        if (mis) begin
            e = '{default: 0}; e.busy = 1; e.rv = 1; e.mis = 1; expQ.push_back(e); n = 1;
        end else if (!wr) begin
            e = '{default: 0}; e.busy = 1; e.rd = 1; e.addr = {27'd0, idx}; expQ.push_back(e);
            e = '{default: 0}; e.busy = 1; e.rv = 1; e.rdata = refLoad(refMem[idx], sz, uns, a); expQ.push_back(e);
            n = 2;
        end else begin
            nw = refStore(refMem[idx], wd, sz, a);
            if (!sz[1]) begin
                e = '{default: 0}; e.busy = 1; e.rd = 1; e.addr = {27'd0, idx}; expQ.push_back(e); n = 1;
            end
            e = '{default: 0}; e.busy = 1; e.wr = 1; e.addr = {27'd0, idx}; e.wd = nw; expQ.push_back(e);
            e = '{default: 0}; e.busy = 1; e.rv = 1; expQ.push_back(e);
            n += 2;
            refMem[idx] = nw;
        end
        req_valid = 1; req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
            req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
        end
        @(posedge Clk); #1;
        req_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        int st;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[7] = 32'h29A;
        mem[9] = 32'h22B;
        for (int i = 0; i < 32; i++) refMem[i] = mem[i];
        reset = 0;
        idle(3);
        chkOn = 1;
        chk("reset Address", Address, 0);
        chk("reset WriteData", WriteData, 0);
        chk("reset resp_rdata", resp_rdata, 0);
        reset = 1;
        idle(1);

        st = cycCnt; issue(0, 2'b10, 0, 32'h1C, 0);
        chk("lw 0x1C", lastRdata, 32'h0000_029A);
        chk("lw latency", respCyc - st, 2);
        issue(0, 2'b00, 0, 32'h1C, 0); chk("lb 0x1C", lastRdata, 32'hFFFF_FF9A);
        issue(0, 2'b00, 1, 32'h1C, 0); chk("lbu 0x1C", lastRdata, 32'h0000_009A);
        issue(0, 2'b01, 1, 32'h26, 0); chk("lhu 0x26", lastRdata, 32'h0000_0000);
        issue(0, 2'b01, 0, 32'h24, 0); chk("lh 0x24", lastRdata, 32'h0000_022B);
        st = cycCnt; issue(1, 2'b00, 0, 32'h25, 32'hAB);
        chk("sb WriteData", lastWd, 32'h0000_AB2B);
        chk("sb latency", respCyc - st, 3);
        issue(0, 2'b10, 0, 32'h24, 0); chk("lw after sb", lastRdata, 32'h0000_AB2B);
        st = cycCnt; issue(1, 2'b10, 0, 32'h00, 32'hDEAD_BEEF);
        chk("sw WriteData", lastWd, 32'hDEAD_BEEF);
        chk("sw latency", respCyc - st, 2);
        issue(0, 2'b10, 0, 32'h00, 0); chk("lw after sw", lastRdata, 32'hDEAD_BEEF);

        // reset asserted during the RD cycle of a load
        begin
            cycT e;
            e = '{default: 0}; expQ.push_back(e);
            e.busy = 1; e.rd = 1; e.addr = 32'd7; expQ.push_back(e);
            req_valid = 1; req_write = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 32'h1C;
            @(posedge Clk); #1;
            req_valid = 0;
            reset = 0;
            @(posedge Clk); #1;
            chk("rst mid Address", Address, 0);
            chk("rst mid WriteData", WriteData, 0);
            chk("rst mid resp_rdata", resp_rdata, 0);
            reset = 1;
            idle(1);
        end
        issue(0, 2'b10, 0, 32'h1C, 0); chk("lw after reset", lastRdata, 32'h0000_029A);

`ifdef MISALIGN_TRAP_EN
        issue(0, 2'b10, 0, 32'h1D, 0); chk("lw 0x1D trap", lastRdata, 32'h0);
`else
        issue(0, 2'b10, 0, 32'h1D, 0); chk("lw 0x1D", lastRdata, 32'h0000_029A);
        issue(0, 2'b01, 0, 32'h1F, 0); chk("lh 0x1F", lastRdata, 32'h0000_0000);
`endif

        for (int t = 0; t < 300; t++) begin
            issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        for (int i = 0; i < 32; i++) chk("final mem", mem[i], refMem[i]);
        $display("%0d/%0d checks passed", passCnt, total);
        $finish;
    end
endmodule
